// File: rtl/branch_resolver.sv
// Branch resolution and direct-mapped prediction unit: resolves the ID-stage
// branch, redirects fetch on a mispredict, and trains a 2-bit counter/target table.
module branch_resolver #(
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_target,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  input  logic        compout,
  input  logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CTR_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [CTR_W-1:0] ctr_q   [BHT_ENTRIES];
  logic             valid_q [BHT_ENTRIES];
  logic [PC_W-1:0]  tgt_q   [BHT_ENTRIES];

  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [CTR_W-1:0] ctr_old, ctr_d;
  logic             accept, mispredict;
  logic [PC_W-1:0]  actual_pc;

  // Only the index bits of either PC address the table; the rest are tag-free.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            id_pc[PC_W-1:IDX_W+2], id_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];

  // Fetch lookup reads registered table state only.
  assign pred_taken  = valid_q[if_idx] & ctr_q[if_idx][1];
  assign pred_target = tgt_q[if_idx];

  assign accept     = id_valid && !stall && (state_q == ST_IDLE);
  assign actual_pc  = compout ? id_target : id_pc + PC_W'(4);
  assign mispredict = (compout != id_pred_taken) ||
                      (compout && (id_pred_target != id_target));

  always_comb begin
    ctr_old = ctr_q[id_idx];
    ctr_d   = ctr_old;
    if (compout && (ctr_old != 2'b11)) begin
      ctr_d = ctr_old + CTR_W'(1);
    end else if (!compout && (ctr_old != 2'b00)) begin
      ctr_d = ctr_old - CTR_W'(1);
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    redirect_pc_d      = redirect_pc_q;
    if (accept) begin
      if (branch_count_q != {CNT_W{1'b1}}) begin
        branch_count_d = branch_count_q + CNT_W'(1);
      end
      if (mispredict) begin
        redirect_pc_d = actual_pc;
        if (mispredict_count_q != {CNT_W{1'b1}}) begin
          mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        ctr_q[i]   <= 2'b01;
        valid_q[i] <= 1'b0;
        tgt_q[i]   <= '0;
      end
    end else if (accept) begin
      ctr_q[id_idx]   <= ctr_d;
      valid_q[id_idx] <= 1'b1;
      if (compout) begin
        tgt_q[id_idx] <= id_target;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Redirect FSM: state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect FSM: next state; a stalled redirect is held until fetch can take it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept && mispredict) state_d = ST_REDIRECT;
      ST_REDIRECT: if (!stall)               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Redirect FSM: outputs decoded from the state register only.
  always_comb begin
    redirect = 1'b0;
    flush    = 1'b0;
    if (state_q == ST_REDIRECT) begin
      redirect = 1'b1;
      flush    = 1'b1;
    end
  end

  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized and directed checks of branch_resolver against a behavioural
// predictor/redirect model kept in the bench.
module tb_branch_resolver;

  localparam int unsigned N = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_target = '0;
  logic        id_pred_taken = 1'b0;
  logic [31:0] id_pred_target = '0;
  logic        compout = 1'b0;
  logic        stall = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  branch_resolver #(.BHT_ENTRIES(N)) dut (
    .clock(clock), .reset_n(reset_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .id_valid(id_valid), .id_pc(id_pc), .id_target(id_target),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .compout(compout), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_cnt [N];
  bit          m_val [N];
  logic [31:0] m_tgt [N];
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_cnt[i] = 1; m_val[i] = 0; m_tgt[i] = '0;
    end
    m_redir = 0; m_rpc = '0; m_bc = 0; m_mc = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptg, input bit c,
                       input bit st, input logic [31:0] fpc);
    id_valid = v; id_pc = pc; id_target = tgt; id_pred_taken = pt;
    id_pred_target = ptg; compout = c; stall = st; if_pc = fpc;
  endtask

  // One clock: check lookup, clock the DUT, advance the model, check registered outputs.
  task automatic cycle();
    int  i;
    bit  acc, mis, nredir;
    logic [31:0] actual;
    #1;
    i = idx_of(if_pc);
    chk("pred_taken", 32'(pred_taken), 32'(m_val[i] && m_cnt[i] >= 2));
    chk("pred_target", pred_target, m_tgt[i]);
    acc    = id_valid && !stall && !m_redir;
    actual = compout ? id_target : id_pc + 32'd4;
    mis    = (compout != id_pred_taken) || (compout && id_pred_target != id_target);
    nredir = m_redir ? stall : (acc && mis);
    @(posedge clock);
    #1;
    if (acc) begin
      i = idx_of(id_pc);
      m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
      m_cnt[i] = compout ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                         : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      m_val[i] = 1;
      if (compout) m_tgt[i] = id_target;
      if (mis) begin
        m_mc  = (m_mc < 65535) ? m_mc + 1 : 65535;
        m_rpc = actual;
      end
    end
    m_redir = nredir;
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("flush", 32'(flush), 32'(m_redir));
    if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
    chk("branch_count", 32'(branch_count), 32'(m_bc));
    chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(0, 32'h0, 32'h0, 0, 32'h0, 0, 0, fpc);
    cycle();
  endtask

  initial begin
    logic [31:0] pc, tgt, ptg;
    bit c, pt;
    model_reset();
    #12 reset_n = 1'b1;
    @(posedge clock); #1;

    // Reset state
    if_pc = 32'h40; #1;
    chk("rst_pred_taken", 32'(pred_taken), 32'h0);
    chk("rst_pred_target", pred_target, 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_counts", {branch_count, mispredict_count}, 32'h0);

    // Cold taken branch
    drive(1, 32'h40, 32'h100, 0, 32'h0, 1, 0, 32'h40); cycle();
    chk("cold_rpc", redirect_pc, 32'h100);
    chk("cold_redirect", 32'(redirect), 32'h1);
    idle(32'h40);
    chk("cold_redirect_drop", 32'(redirect), 32'h0);
    chk("cold_lookup_taken", 32'(pred_taken), 32'h1);
    chk("cold_lookup_target", pred_target, 32'h100);

    // Predicted taken, actually not taken
    drive(1, 32'h40, 32'h100, 1, 32'h100, 0, 0, 32'h40); cycle();
    chk("nt_rpc", redirect_pc, 32'h44);
    idle(32'h40);

    // Correct prediction, no redirect
    drive(1, 32'h40, 32'h100, 1, 32'h100, 1, 0, 32'h40); cycle();
    chk("correct_noredirect", 32'(redirect), 32'h0);

    // Saturation and aliasing at index 0
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h40, 32'h100, 1, 32'h100, 1, 0, 32'h40); cycle();
    end
    drive(1, 32'h40, 32'h100, 1, 32'h100, 0, 0, 32'h40); cycle();
    idle(32'h40);
    chk("sat_still_taken", 32'(pred_taken), 32'h1);
    drive(1, 32'h80, 32'h300, 1, 32'h100, 1, 0, 32'h40); cycle();
    idle(32'h40);
    chk("alias_target", pred_target, 32'h300);

    // PC wrap on not-taken
    drive(1, 32'hFFFF_FFFC, 32'h0, 1, 32'h8, 0, 0, 32'h0); cycle();
    chk("wrap_rpc", redirect_pc, 32'h0);
    idle(32'h0);

    // Stalled redirect hold with wrong-path id_valid
    drive(1, 32'h48, 32'h200, 0, 32'h0, 1, 0, 32'h48); cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h48, 32'h200, 0, 32'h0, 1, 1, 32'h48); cycle();
      chk("hold_rpc", redirect_pc, 32'h200);
    end
    drive(1, 32'h48, 32'h200, 0, 32'h0, 1, 0, 32'h48); cycle();
    chk("hold_release", 32'(redirect), 32'h0);
    idle(32'h48);

    // Reset during a held redirect
    drive(1, 32'h4C, 32'h400, 0, 32'h0, 1, 0, 32'h4C); cycle();
    drive(0, 32'h0, 32'h0, 0, 32'h0, 0, 1, 32'h4C); cycle();
    reset_n = 1'b0; #1;
    chk("async_rst_redirect", 32'(redirect), 32'h0);
    chk("async_rst_flush", 32'(flush), 32'h0);
    chk("async_rst_counts", {branch_count, mispredict_count}, 32'h0);
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    // Acceptance on the first edge after deassertion
    drive(1, 32'h40, 32'h100, 0, 32'h0, 1, 0, 32'h40); cycle();
    chk("post_rst_accept", 32'(branch_count), 32'h1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      pc  = ($urandom & 32'h0000_00FC) | (($urandom & 1) != 0 ? 32'h1000 : 32'h0);
      tgt = ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'h100 * $urandom_range(1, 3);
      c   = 1'($urandom);
      pt  = ($urandom & 1) != 0 ? c : 1'($urandom);
      ptg = ($urandom_range(0, 3) != 0) ? tgt : ($urandom & 32'hFFFF_FFFC);
      drive(1'($urandom_range(0, 9) < 7), pc, tgt, pt, ptg, c,
            1'($urandom_range(0, 4) == 0),
            ($urandom & 1) != 0 ? pc : ($urandom & 32'h0000_1FFC));
      cycle();
    end

    // Branch count saturation with always-correct predictions
    for (int k = 0; k < 65540; k++) begin
      pc = $urandom & 32'h0000_00FC;
      c  = 1'($urandom);
      drive(1, pc, 32'h500, c, 32'h500, c, 0, pc);
      cycle();
    end
    chk("branch_count_sat", 32'(branch_count), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
